// File: rtl/time_set_controller_if.sv
// Button and control bundle between the time-set controller and its peers.
// master: drives btn_mode/btn_up, observes pulses, mode and blink mask.
interface time_set_controller_if;
  logic       btn_mode;
  logic       btn_up;
  logic       sec_tick_en;
  logic       inc_hour;
  logic       inc_min;
  logic       clr_sec;
  logic [1:0] mode;
  logic [3:0] blink_mask;

  modport master (
    output btn_mode, btn_up,
    input  sec_tick_en, inc_hour, inc_min,
    input  clr_sec, mode, blink_mask
  );

  modport slave (
    input  btn_mode, btn_up,
    output sec_tick_en, inc_hour, inc_min,
    output clr_sec, mode, blink_mask
  );
endinterface

// File: rtl/time_set_controller.sv
// Time-set controller: 1 Hz seconds enable plus RUN/SET_HOUR/SET_MIN FSM.
// Optional macro AUTO_REPEAT_EN adds held-button auto-repeat of inc pulses.
// Ports: CLK100MHZ (clock), reset (sync, active high), bus (slave):
//   in  btn_mode, btn_up      debounced button levels
//   out sec_tick_en           1-cycle seconds advance
//   out inc_hour, inc_min     1-cycle counter increments
//   out clr_sec               1-cycle seconds clear on leaving SET_MIN
//   out mode[1:0]             00 RUN, 01 SET_HOUR, 10 SET_MIN
//   out blink_mask[3:0]       digit enables, [3:2] hours, [1:0] minutes
module time_set_controller #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_S  = 10,
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  time_set_controller_if.slave bus
);

  localparam int HALF = CLK_HZ / 2;
  localparam int PW   = $clog2(CLK_HZ + 1);
  localparam int BW   = $clog2(HALF + 1);
  localparam int SW   = $clog2(TIMEOUT_S + 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  state_t          state, state_n;
  logic            btn_mode_q, btn_up_q;
  logic            mode_edge, up_edge, rep_fire, bump;
  logic [PW-1:0]   presc, presc_n;
  logic [BW-1:0]   blink_cnt, blink_cnt_n;
  logic            phase, phase_n;
  logic [PW-1:0]   tmo_cyc, tmo_cyc_n;
  logic [SW-1:0]   tmo_sec, tmo_sec_n;
  logic            tick_n, inc_hour_n, inc_min_n, clr_sec_n;
  logic [3:0]      mask_n;

  assign mode_edge = bus.btn_mode & ~btn_mode_q;
  assign up_edge   = bus.btn_up & ~btn_up_q;
  assign bump      = up_edge | rep_fire;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int RW   = $clog2(RMAX + 1);

  logic          rep_arm, rep_arm_n;
  logic          rep_first, rep_first_n;
  logic [RW-1:0] rep_cnt, rep_cnt_n;
  logic [RW-1:0] rep_last;

  // First repeat waits HOLD_CYC, later ones REPEAT_CYC.
  assign rep_last = rep_first ? RW'(HOLD_CYC - 1) : RW'(REPEAT_CYC - 1);
  assign rep_fire = rep_arm && bus.btn_up && (state != RUN)
                    && (rep_cnt == rep_last);

  always_comb begin
    rep_arm_n   = rep_arm;
    rep_first_n = rep_first;
    rep_cnt_n   = rep_cnt;
    if (state_n != state || state == RUN || !bus.btn_up) begin
      rep_arm_n   = 1'b0;
      rep_first_n = 1'b1;
      rep_cnt_n   = '0;
    end else if (up_edge) begin
      rep_arm_n   = 1'b1;
      rep_first_n = 1'b1;
      rep_cnt_n   = '0;
    end else if (rep_arm) begin
      if (rep_fire) begin
        rep_first_n = 1'b0;
        rep_cnt_n   = '0;
      end else begin
        rep_cnt_n = rep_cnt + RW'(1);
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      rep_arm   <= 1'b0;
      rep_first <= 1'b1;
      rep_cnt   <= '0;
    end else begin
      rep_arm   <= rep_arm_n;
      rep_first <= rep_first_n;
      rep_cnt   <= rep_cnt_n;
    end
  end
`else
  logic unused_rep;
  assign unused_rep = ^{HOLD_CYC, REPEAT_CYC};
  assign rep_fire   = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    tick_n      = 1'b0;
    inc_hour_n  = 1'b0;
    inc_min_n   = 1'b0;
    clr_sec_n   = 1'b0;
    presc_n     = '0;
    tmo_cyc_n   = tmo_cyc;
    tmo_sec_n   = tmo_sec;
    blink_cnt_n = blink_cnt;
    phase_n     = phase;
    mask_n      = 4'b1111;

    // Mode edge always wins over an up edge in the same cycle.
    unique case (state)
      RUN: begin
        if (mode_edge) begin
          state_n = SET_HOUR;
        end else if (presc == PW'(CLK_HZ - 1)) begin
          tick_n = 1'b1;
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      SET_HOUR: begin
        if (mode_edge)  state_n    = SET_MIN;
        else if (bump)  inc_hour_n = 1'b1;
      end
      SET_MIN: begin
        if (mode_edge) begin
          state_n   = RUN;
          clr_sec_n = 1'b1;
        end else if (bump) begin
          inc_min_n = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase

    // Idle timeout: whole seconds without activity return to RUN silently.
    if (state != RUN) begin
      if (mode_edge || bump) begin
        tmo_cyc_n = '0;
        tmo_sec_n = '0;
      end else if (tmo_cyc == PW'(CLK_HZ - 1)) begin
        tmo_cyc_n = '0;
        if (tmo_sec == SW'(TIMEOUT_S - 1)) begin
          state_n   = RUN;
          tmo_sec_n = '0;
        end else begin
          tmo_sec_n = tmo_sec + SW'(1);
        end
      end else begin
        tmo_cyc_n = tmo_cyc + PW'(1);
      end
    end
    if (state_n != state) begin
      tmo_cyc_n = '0;
      tmo_sec_n = '0;
    end

    // Digits show solid right after entry or an increment.
    if (state_n != state || inc_hour_n || inc_min_n) begin
      blink_cnt_n = '0;
      phase_n     = 1'b1;
    end else if (state != RUN) begin
      if (blink_cnt == BW'(HALF - 1)) begin
        blink_cnt_n = '0;
        phase_n     = ~phase;
      end else begin
        blink_cnt_n = blink_cnt + BW'(1);
      end
    end

    unique case (state_n)
      SET_HOUR: mask_n = {phase_n, phase_n, 2'b11};
      SET_MIN:  mask_n = {2'b11, phase_n, phase_n};
      default:  mask_n = 4'b1111;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state           <= RUN;
      btn_mode_q      <= bus.btn_mode;
      btn_up_q        <= bus.btn_up;
      presc           <= '0;
      tmo_cyc         <= '0;
      tmo_sec         <= '0;
      blink_cnt       <= '0;
      phase           <= 1'b1;
      bus.sec_tick_en <= 1'b0;
      bus.inc_hour    <= 1'b0;
      bus.inc_min     <= 1'b0;
      bus.clr_sec     <= 1'b0;
      bus.mode        <= 2'b00;
      bus.blink_mask  <= 4'b1111;
    end else begin
      state           <= state_n;
      btn_mode_q      <= bus.btn_mode;
      btn_up_q        <= bus.btn_up;
      presc           <= presc_n;
      tmo_cyc         <= tmo_cyc_n;
      tmo_sec         <= tmo_sec_n;
      blink_cnt       <= blink_cnt_n;
      phase           <= phase_n;
      bus.sec_tick_en <= tick_n;
      bus.inc_hour    <= inc_hour_n;
      bus.inc_min     <= inc_min_n;
      bus.clr_sec     <= clr_sec_n;
      bus.mode        <= state_n;
      bus.blink_mask  <= mask_n;
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with small timing parameters.
// Cycle 0 is the first cycle after reset is released.
module tb_time_set_controller;

  localparam int CLK_HZ     = 10;
  localparam int TIMEOUT_S  = 3;
  localparam int HOLD_CYC   = 8;
  localparam int REPEAT_CYC = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  time_set_controller_if bus ();

  time_set_controller #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_S  (TIMEOUT_S),
    .HOLD_CYC   (HOLD_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .bus       (bus)
  );

  typedef struct {
    logic       bm;
    logic       bu;
    logic       tick;
    logic       ih;
    logic       im;
    logic       clr;
    logic [1:0] mode;
    logic [3:0] mask;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic       s_tick, s_ih, s_im, s_clr;
  logic [1:0] s_mode;
  logic [3:0] s_mask;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs for the current cycle, sample outputs mid-cycle.
  task automatic step(input logic bm, input logic bu);
    bus.btn_mode = bm;
    bus.btn_up   = bu;
    @(negedge clk);
    s_tick = bus.sec_tick_en;
    s_ih   = bus.inc_hour;
    s_im   = bus.inc_min;
    s_clr  = bus.clr_sec;
    s_mode = bus.mode;
    s_mask = bus.blink_mask;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic bm, input logic bu);
    bus.btn_mode = bm;
    bus.btn_up   = bu;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tv[14];
    int   npulse;
    int   exp_total;
    logic exp_p;
    logic bu;

    // Mode/up sequence: outputs expected in the same cycle row.
    tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'hF};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'hF};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'hF};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'hF};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 4'hF};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'hF};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 4'hF};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'hF};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'hF};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'hF};
    tv[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 4'hF};
    tv[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'hF};
    tv[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'hF};
    tv[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'hF};

    // 1: idle RUN, ticks at cycles 10, 20, 30.
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < 35; c++) begin
      step(1'b0, 1'b0);
      chk($sformatf("t1[%0d] tick", c), 32'(s_tick),
          32'((c == 10) || (c == 20) || (c == 30)));
      chk($sformatf("t1[%0d] outs", c),
          32'({s_ih, s_im, s_clr, s_mode, s_mask}), 32'h00F);
    end

    // 2: table-driven mode/up sequence.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(tv[i].bm, tv[i].bu);
      chk($sformatf("t2[%0d] outs", i),
          32'({s_tick, s_ih, s_im, s_clr, s_mode, s_mask}),
          32'({tv[i].tick, tv[i].ih, tv[i].im, tv[i].clr,
               tv[i].mode, tv[i].mask}));
    end

    // 3: simultaneous mode+up from RUN, then hour-digit blink.
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    for (int k = 0; k < 15; k++) begin
      step(1'b1, 1'b1);
      chk($sformatf("t3[%0d] mode", k), 32'(s_mode), 32'(2'b01));
      chk($sformatf("t3[%0d] inc_hour", k), 32'(s_ih), 32'(1'b0));
      chk($sformatf("t3[%0d] mask", k), 32'(s_mask),
          (((k / 5) % 2) == 0) ? 32'hF : 32'h3);
    end

    // 4: SET_MIN timeout back to RUN, no clr_sec, tick 10 later.
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int k = 0; k < 46; k++) begin
      step(1'b0, 1'b0);
      chk($sformatf("t4[%0d] mode", k), 32'(s_mode),
          (k < 30) ? 32'(2'b10) : 32'(2'b00));
      chk($sformatf("t4[%0d] clr_sec", k), 32'(s_clr), 32'(1'b0));
      chk($sformatf("t4[%0d] tick", k), 32'(s_tick), 32'(k == 40));
    end

    // 5a: buttons held through reset produce no edge.
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1);
      chk($sformatf("t5[%0d] mode", k), 32'(s_mode), 32'(2'b00));
      chk($sformatf("t5[%0d] pulses", k),
          32'({s_ih, s_im, s_clr}), 32'(3'b000));
    end
    // 5b: reset while in SET_MIN with minute digits blanked.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b0);
      if (k == 0) chk("t5 set_min mode", 32'(s_mode), 32'(2'b10));
      if (k == 6) chk("t5 set_min mask", 32'(s_mask), 32'hC);
    end
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0);
    chk("t5 post-reset mode", 32'(s_mode), 32'(2'b00));
    chk("t5 post-reset mask", 32'(s_mask), 32'hF);
    chk("t5 post-reset pulses",
        32'({s_tick, s_ih, s_im, s_clr}), 32'(4'b0000));
    step(1'b0, 1'b0);
    chk("t5 post-reset+1 pulses",
        32'({s_tick, s_ih, s_im, s_clr}), 32'(4'b0000));

    // 6: up held 20 cycles after its edge in SET_HOUR.
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    npulse = 0;
    for (int j = 1; j <= 26; j++) begin
      bu = (j <= 20);
      step(1'b0, bu);
`ifdef AUTO_REPEAT_EN
      exp_p = (j == 1) || (j == 9) || (j == 13) || (j == 17) || (j == 21);
`else
      exp_p = (j == 1);
`endif
      if (s_ih === 1'b1) npulse++;
      chk($sformatf("t6[%0d] inc_hour", j), 32'(s_ih), 32'(exp_p));
    end
`ifdef AUTO_REPEAT_EN
    exp_total = 5;
`else
    exp_total = 1;
`endif
    chk("t6 pulse total", 32'(npulse), 32'(exp_total));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
